// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM engine: shared prescaled frame counter, per-channel
// shadowed duty/mode registers applied at frame boundaries (off/static/breathe/blink).
module led_pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [1:0]          wr_mode,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_t;

    logic                tick;
    logic                boundary;
    logic                wr_valid;
    logic [WIDTH-1:0]    cnt;

    logic [WIDTH-1:0]    shadow_duty [CHANNELS];
    mode_t               shadow_mode [CHANNELS];
    logic [WIDTH-1:0]    active_duty [CHANNELS];
    mode_t               active_mode [CHANNELS];
    logic [WIDTH-1:0]    level       [CHANNELS];
    logic [WIDTH-1:0]    load_duty   [CHANNELS];
    mode_t               load_mode   [CHANNELS];
    logic [WIDTH-1:0]    next_level  [CHANNELS];
    logic [WIDTH-1:0]    eff         [CHANNELS];
    logic [CHANNELS-1:0] dir_down;
    logic [CHANNELS-1:0] next_down;
    logic [CHANNELS-1:0] blink;
    logic [CHANNELS-1:0] wr_hit;

    generate
        if (PRESCALE > 0) begin : g_pre
            logic [PRESCALE-1:0] pre;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pre <= '0;
                end else if (ena) begin
                    pre <= pre + PRESCALE'(1);
                end
            end
            assign tick = ena && (pre == '1);
        end else begin : g_no_pre
            assign tick = ena;
        end
    endgenerate

    assign boundary = tick && (cnt == '1);
    assign wr_valid = wr_en && (32'(wr_chan) < 32'(CHANNELS));

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_valid && (32'(wr_chan) == i);
        end
    end

    // Values entering active at a boundary; a write in that same cycle bypasses shadow.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_duty[i]  = wr_hit[i] ? wr_duty : shadow_duty[i];
            load_mode[i]  = wr_hit[i] ? mode_t'(wr_mode) : shadow_mode[i];
            next_level[i] = '0;
            next_down[i]  = 1'b0;
            if (load_mode[i] == MODE_BREATHE) begin
                if (level[i] > load_duty[i]) begin
                    next_level[i] = load_duty[i];
                    next_down[i]  = 1'b1;
                end else if (!dir_down[i]) begin
                    if (level[i] == load_duty[i]) begin
                        next_down[i]  = 1'b1;
                        next_level[i] = (load_duty[i] == '0) ? '0 : load_duty[i] - WIDTH'(1);
                    end else begin
                        next_level[i] = level[i] + WIDTH'(1);
                    end
                end else begin
                    if (level[i] == '0) begin
                        next_down[i]  = 1'b0;
                        next_level[i] = (load_duty[i] == '0) ? '0 : WIDTH'(1);
                    end else begin
                        next_down[i]  = 1'b1;
                        next_level[i] = level[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            eff[i] = '0;
            unique case (active_mode[i])
                MODE_OFF:     eff[i] = '0;
                MODE_STATIC:  eff[i] = active_duty[i];
                MODE_BREATHE: eff[i] = level[i];
                MODE_BLINK:   eff[i] = blink[i] ? active_duty[i] : '0;
                default:      eff[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            pwm         <= '0;
            dir_down    <= '0;
            blink       <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_duty[i] <= '0;
                shadow_mode[i] <= MODE_OFF;
                active_duty[i] <= '0;
                active_mode[i] <= MODE_OFF;
                level[i]       <= '0;
            end
        end else begin
            if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end
            frame_start <= boundary;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pwm[i] <= (cnt < eff[i]);
                if (wr_hit[i]) begin
                    shadow_duty[i] <= wr_duty;
                    shadow_mode[i] <= mode_t'(wr_mode);
                end
                if (boundary) begin
                    active_duty[i] <= load_duty[i];
                    active_mode[i] <= load_mode[i];
                    level[i]       <= next_level[i];
                    dir_down[i]    <= next_down[i];
                    blink[i]       <= (load_mode[i] == MODE_BLINK) ? ~blink[i] : 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench for led_pwm_bank: a frame-level model predicts per-channel
// high counts per frame; a monitor measures each frame and compares.
module tb_led_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_chan = '0;
    logic [3:0] wr_duty = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] pwm;
    logic       frame_start;

    logic       wr_en5 = 1'b0;
    logic [2:0] wr_chan5 = '0;
    logic [4:0] pwm5;
    logic       frame_start5;

    int total = 0;
    int bad = 0;

    led_pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(0)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en), .wr_chan(wr_chan),
        .wr_duty(wr_duty), .wr_mode(wr_mode), .pwm(pwm), .frame_start(frame_start)
    );

    led_pwm_bank #(.CHANNELS(5), .WIDTH(4), .PRESCALE(0)) u_dut5 (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en5), .wr_chan(wr_chan5),
        .wr_duty(wr_duty), .wr_mode(wr_mode), .pwm(pwm5), .frame_start(frame_start5)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame granularity) ----------------
    int mcnt;
    int en_edges;
    bit ena_q;
    int sh_d [4];
    int sh_m [4];
    int lvl  [4];
    int dn   [4];
    int blk  [4];
    int exp_q [$];

    task automatic model_reset();
        mcnt = 0;
        en_edges = 0;
        ena_q = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sh_d[c] = 0; sh_m[c] = 0; lvl[c] = 0; dn[c] = 0; blk[c] = 0;
        end
        exp_q.delete();
        for (int c = 0; c < 4; c++) exp_q.push_back(0);
    endtask

    initial begin
        int p, m, e;
        bit hit;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                ena_q = ena;
                if (ena) en_edges++;
                if (ena && mcnt == 15) begin
                    for (int c = 0; c < 4; c++) begin
                        hit = wr_en && (int'(wr_chan) == c);
                        p = hit ? int'(wr_duty) : sh_d[c];
                        m = hit ? int'(wr_mode) : sh_m[c];
                        if (m == 2) begin
                            if (lvl[c] > p) begin
                                lvl[c] = p; dn[c] = 1;
                            end else if (dn[c] == 0) begin
                                if (lvl[c] == p) begin dn[c] = 1; lvl[c] = (p > 0) ? p - 1 : 0; end
                                else lvl[c] = lvl[c] + 1;
                            end else begin
                                if (lvl[c] == 0) begin dn[c] = 0; lvl[c] = (p > 0) ? 1 : 0; end
                                else lvl[c] = lvl[c] - 1;
                            end
                        end else begin
                            lvl[c] = 0; dn[c] = 0;
                        end
                        blk[c] = (m == 3) ? 1 - blk[c] : 0;
                        case (m)
                            0: e = 0;
                            1: e = p;
                            2: e = lvl[c];
                            default: e = (blk[c] != 0) ? p : 0;
                        endcase
                        exp_q.push_back(e);
                    end
                end
                if (ena) mcnt = (mcnt + 1) % 16;
                if (wr_en) begin
                    sh_d[wr_chan] = int'(wr_duty);
                    sh_m[wr_chan] = int'(wr_mode);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int hi [4];
        int prev_edges;
        int e;
        prev_edges = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_edges = 0;
                for (int c = 0; c < 4; c++) hi[c] = 0;
            end else begin
                if (ena_q) begin
                    for (int c = 0; c < 4; c++) hi[c] += int'(pwm[c]);
                end
                if (frame_start) begin
                    check("frame_period_enabled_clocks", en_edges - prev_edges, 16);
                    if (exp_q.size() < 4) begin
                        check("scoreboard_underflow", exp_q.size(), 4);
                    end else begin
                        for (int c = 0; c < 4; c++) begin
                            e = exp_q.pop_front();
                            check($sformatf("frame_high_count_ch%0d", c), hi[c], e);
                        end
                    end
                    prev_edges = en_edges;
                    for (int c = 0; c < 4; c++) hi[c] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d, input int m);
        @(negedge clk);
        wr_en = 1'b1; wr_chan = ch[1:0]; wr_duty = d[3:0]; wr_mode = m[1:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wr5(input int ch, input int d, input int m);
        @(negedge clk);
        wr_en5 = 1'b1; wr_chan5 = ch[2:0]; wr_duty = d[3:0]; wr_mode = m[1:0];
        @(negedge clk);
        wr_en5 = 1'b0;
    endtask

    initial begin
        logic [3:0] hold;
        int cnt5 [5];
        int k;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_frame_start", int'(frame_start), 0);
        rst = 1'b0;

        wait_clks(5);
        wr(0, 8, 1);
        wait_clks(48);
        wr(1, 3, 2);
        wr(2, 15, 3);
        wr(3, 0, 1);

        // re-peak the breathing channel while it sits at its top level
        k = 0;
        while (k < 200 && lvl[1] != 3) begin
            @(negedge clk);
            k++;
        end
        check("breathe_reached_level3", lvl[1], 3);
        wr(1, 1, 2);
        wait_clks(80);
        wr(3, 15, 1);
        wait_clks(32);

        // write landing exactly on the boundary cycle
        k = 0;
        @(negedge clk);
        while (k < 40 && mcnt != 15) begin
            @(negedge clk);
            k++;
        end
        check("boundary_cycle_found", mcnt, 15);
        wr_en = 1'b1; wr_chan = 2'd0; wr_duty = 4'd3; wr_mode = 2'd1;
        @(negedge clk);
        wr_en = 1'b0;
        wait_clks(20);

        wr(0, 5, 1);
        wr(0, 11, 1);
        wait_clks(40);

        wait_clks(6);
        ena = 1'b0;
        hold = pwm;
        repeat (10) begin
            @(negedge clk);
            check("freeze_pwm_hold", int'(pwm), int'(hold));
        end
        ena = 1'b1;
        wait_clks(40);

        for (int it = 0; it < 30; it++) begin
            wait_clks(int'($urandom_range(1, 20)));
            if ($urandom_range(0, 3) == 0) begin
                ena = 1'b0;
                wait_clks(int'($urandom_range(1, 6)));
                ena = 1'b1;
            end
            wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
        wait_clks(48);

        // five-channel build: channels 5..7 are out of range, 4 is valid
        wr5(5, 15, 1);
        wr5(6, 15, 1);
        wr5(7, 9, 3);
        wr5(4, 6, 1);
        wait_clks(40);
        for (int c = 0; c < 5; c++) cnt5[c] = 0;
        repeat (16) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++) cnt5[c] += int'(pwm5[c]);
        end
        for (int c = 0; c < 4; c++) check($sformatf("five_ch_unwritten_ch%0d", c), cnt5[c], 0);
        check("five_ch_ch4_duty", cnt5[4], 6);

        wr(3, 15, 1);
        wait_clks(40);
        @(negedge clk);
        while (pwm[3] != 1'b1) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_pwm", int'(pwm), 0);
        check("async_reset_frame_start", int'(frame_start), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_clks(40);
        check("scoreboard_pending_after_reset", exp_q.size(), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
